wfg_drive_pat_engine: RTL and testbench

WFG_DRIVE_PAT_ENGINE -- requirements
Module: wfg_drive_pat_engine

---
 rtl/wfg_drive_pat_pkg.sv | 6 +
 rtl/wfg_drive_pat_lane.sv | 29 ++
 rtl/wfg_drive_pat_engine.sv | 71 +++++++
 tb/tb_wfg_drive_pat_engine.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wfg_drive_pat_pkg.sv
// wfg_drive_pat_pkg: shared pattern modes and default sizing for the drive pattern engine
package wfg_drive_pat_pkg;
  typedef enum logic [1:0] {RZ = 2'b00, RO = 2'b01, NRZ = 2'b10, RC = 2'b11} patsel_e;
  localparam int DEF_CHANNELS = 8;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/wfg_drive_pat_lane.sv
// wfg_drive_pat_lane: one output bit driven at begin, returned to its pattern at end
module wfg_drive_pat_lane
  import wfg_drive_pat_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cycles,
  input  logic [CNT_W-1:0] beg,
  input  logic [CNT_W-1:0] fin,
  input  patsel_e          mode,
  input  logic             sample,
  output logic             bit_q
);
  logic bit_d, hit_b, hit_e, ret;
  always_comb begin
    hit_b = cnt == beg && beg <= cycles;
    hit_e = cnt == fin && fin <= cycles;
    ret = mode == RZ ? 1'b0 : mode == RO ? 1'b1 : mode == NRZ ? bit_q : ~bit_q;
    bit_d = !en ? 1'b0 : hit_e ? ret : hit_b ? sample : bit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) bit_q <= 1'b0;
    else bit_q <= bit_d;
  end
endmodule

// File: rtl/wfg_drive_pat_engine.sv
// wfg_drive_pat_engine: subcycle counter, stream handshake and per-channel pattern lanes.
// Optional WFG_DRIVE_PAT_INV_EN adds cfg_inv_q_i, a per-channel output inversion.
module wfg_drive_pat_engine
  import wfg_drive_pat_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_en_q_i,
  input  logic [CNT_W-1:0]          cfg_cycles_q_i,
  input  logic [2*CHANNELS-1:0]     patsel_q_i,
  input  logic [CHANNELS*CNT_W-1:0] cfg_begin_q_i,
  input  logic [CHANNELS*CNT_W-1:0] cfg_end_q_i,
  input  logic                      s_axis_tvalid_i,
  output logic                      s_axis_tready_o,
  input  logic [CHANNELS-1:0]       s_axis_tdata_i,
  input  logic                      clr_underflow_i,
`ifdef WFG_DRIVE_PAT_INV_EN
  input  logic [CHANNELS-1:0]       cfg_inv_q_i,
`endif
  output logic [CHANNELS-1:0]       data_o,
  output logic                      cycle_start_o,
  output logic                      underflow_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] held_q, held_d, sample, lane_q;
  logic und_q, und_d, at_zero, hs;
  always_comb begin
    at_zero = cnt_q == '0;
    s_axis_tready_o = ctrl_en_q_i && at_zero && !rst;
    cycle_start_o = s_axis_tready_o;
    hs = s_axis_tvalid_i && s_axis_tready_o;
    sample = hs ? s_axis_tdata_i : held_q;
    cnt_d = !ctrl_en_q_i ? '0 : cnt_q >= cfg_cycles_q_i ? '0 : cnt_q + 1'b1;
    held_d = !ctrl_en_q_i ? '0 : sample;
    und_d = ctrl_en_q_i && at_zero && !s_axis_tvalid_i ? 1'b1 : clr_underflow_i ? 1'b0 : und_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      held_q <= '0;
      und_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      held_q <= held_d;
      und_q <= und_d;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    wfg_drive_pat_lane #(.CNT_W(CNT_W)) u_lane (
      .clk(clk),
      .rst(rst),
      .en(ctrl_en_q_i),
      .cnt(cnt_q),
      .cycles(cfg_cycles_q_i),
      .beg(cfg_begin_q_i[c*CNT_W +: CNT_W]),
      .fin(cfg_end_q_i[c*CNT_W +: CNT_W]),
      .mode(patsel_e'(patsel_q_i[2*c +: 2])),
      .sample(sample[c]),
      .bit_q(lane_q[c])
    );
  end
`ifdef WFG_DRIVE_PAT_INV_EN
  assign data_o = lane_q ^ cfg_inv_q_i;
`else
  assign data_o = lane_q;
`endif
  assign underflow_o = und_q;
endmodule

// File: tb/tb_wfg_drive_pat_engine.sv
// tb_wfg_drive_pat_engine: scoreboard bench with a behavioural model, directed then random stimulus
module tb_wfg_drive_pat_engine;
  localparam int CH = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, valid, clr, ready, cs, und;
  logic [W-1:0] cycles;
  logic [2*CH-1:0] patsel;
  logic [CH*W-1:0] beg, fin;
  logic [CH-1:0] tdata, data;
`ifdef WFG_DRIVE_PAT_INV_EN
  logic [CH-1:0] inv = 4'b0101;
`endif
  wfg_drive_pat_engine #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_en_q_i(en),
    .cfg_cycles_q_i(cycles),
    .patsel_q_i(patsel),
    .cfg_begin_q_i(beg),
    .cfg_end_q_i(fin),
    .s_axis_tvalid_i(valid),
    .s_axis_tready_o(ready),
    .s_axis_tdata_i(tdata),
    .clr_underflow_i(clr),
`ifdef WFG_DRIVE_PAT_INV_EN
    .cfg_inv_q_i(inv),
`endif
    .data_o(data),
    .cycle_start_o(cs),
    .underflow_o(und)
  );
  typedef struct packed {
    logic [CH-1:0] data;
    logic und;
    logic cs;
    logic rdy;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0, shown = 0;
  int c_cycles, c_b[CH], c_e[CH], c_mode[CH];
  int m_cnt = 0;
  logic [CH-1:0] m_held = '0, m_data = '0;
  logic m_und = 1'b0;
  task automatic chk(string n, logic [CH-1:0] a, logic [CH-1:0] r);
    checks++;
    if (a === r) passed++;
    else if (shown++ < 40) $display("FAIL %s at %0t: got %b expected %b", n, $time, a, r);
  endtask
  // Called at a falling edge: apply inputs, advance the model across the next rising edge, queue the result.
  task automatic step();
    exp_t x;
    logic [CH-1:0] s;
    cycles = W'(c_cycles);
    for (int c = 0; c < CH; c++) begin
      patsel[2*c +: 2] = 2'(c_mode[c]);
      beg[c*W +: W] = W'(c_b[c]);
      fin[c*W +: W] = W'(c_e[c]);
    end
    if (rst) begin
      m_cnt = 0; m_held = '0; m_data = '0; m_und = 1'b0;
    end else if (!en) begin
      m_cnt = 0; m_held = '0; m_data = '0;
      if (clr) m_und = 1'b0;
    end else begin
      s = m_held;
      if (m_cnt == 0 && valid) begin s = tdata; m_held = tdata; end
      if (m_cnt == 0 && !valid) m_und = 1'b1;
      else if (clr) m_und = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (c_e[c] <= c_cycles && m_cnt == c_e[c]) begin
          if (c_mode[c] == 0) m_data[c] = 1'b0;
          else if (c_mode[c] == 1) m_data[c] = 1'b1;
          else if (c_mode[c] == 3) m_data[c] = ~m_data[c];
        end else if (c_b[c] <= c_cycles && m_cnt == c_b[c]) m_data[c] = s[c];
      end
      m_cnt = m_cnt >= c_cycles ? 0 : m_cnt + 1;
    end
    x.data = m_data;
`ifdef WFG_DRIVE_PAT_INV_EN
    x.data = m_data ^ inv;
`endif
    x.und = m_und;
    x.rdy = !rst && en && m_cnt == 0;
    x.cs = x.rdy;
    sb.push_back(x);
    @(negedge clk);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("data_o", data, x.data);
        chk("underflow_o", CH'(und), CH'(x.und));
        chk("cycle_start_o", CH'(cs), CH'(x.cs));
        chk("tready", CH'(ready), CH'(x.rdy));
      end
    end
  end
  task automatic set_all(int mode, int b, int e);
    for (int c = 0; c < CH; c++) begin c_mode[c] = mode; c_b[c] = b; c_e[c] = e; end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; tdata = '0; clr = 1'b0;
    c_cycles = 7;
    set_all(0, 2, 5);
    @(negedge clk);
    repeat (2) step();
    rst = 1'b0; en = 1'b1; valid = 1'b1; tdata = 4'b1011;
    repeat (24) step();
    c_mode[0] = 3; c_b[0] = 0; c_e[0] = 4; tdata = 4'b0001;
    repeat (24) step();
    valid = 1'b0;
    repeat (10) step();
    clr = 1'b1; step(); clr = 1'b0;
    repeat (8) step();
    repeat (24) begin clr = 1'($urandom % 2); step(); end
    clr = 1'b0; valid = 1'b1;
    set_all(1, 3, 3);
    repeat (24) begin tdata = CH'($urandom); step(); end
    set_all(0, 9, 9);
    repeat (20) begin tdata = CH'($urandom); step(); end
    set_all(0, 2, 5); tdata = 4'b1011;
    repeat (12) step();
    while (m_cnt != 4) step();
    en = 1'b0; step(); en = 1'b1;
    repeat (12) step();
    while (m_cnt != 3) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (12) step();
    repeat (60) begin
      c_cycles = $urandom_range(0, 9);
      for (int c = 0; c < CH; c++) begin
        c_mode[c] = $urandom_range(0, 3);
        c_b[c] = $urandom_range(0, 11);
        c_e[c] = $urandom_range(0, 11);
      end
      repeat (25) begin
        en = ($urandom % 40) != 0;
        rst = ($urandom % 80) == 0;
        valid = ($urandom % 5) != 0;
        tdata = CH'($urandom);
        clr = ($urandom % 4) == 0;
        step();
      end
    end
    rst = 1'b0; en = 1'b0; valid = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
